// File: rtl/rectangle128_keysched.sv
// rtl/rectangle128_keysched.sv - RECTANGLE-128 round-key expansion engine
//
// Purpose:
//   Expands a 128-bit master key into 26 64-bit subkeys, one per clock,
//   and writes them to an external subkey memory.
//
// Ports:
//   Clk    in   1    system clock, rising edge
//   flush  in   1    asynchronous active-low reset
//   start  in   1    expansion request, honoured only in IDLE
//   Key    in   128  master key (Row0=Key[31:0] .. Row3=Key[127:96])
//   busy   out  1    high while generating and during the done cycle
//   done   out  1    one-cycle pulse after the last subkey write
//   WE     out  1    subkey write strobe
//   WAddr  out  5    subkey address
//   KeyIn  out  64   subkey data, valid while WE=1
//
// Configuration:
//   RECTANGLE128_KS_REVADDR_EN - when defined, subkey i is written to
//   address 25-i (decryption order); the data sequence is unchanged.

module rectangle128_keysched (
  input  logic         Clk,
  input  logic         flush,
  input  logic         start,
  input  logic [127:0] Key,
  output logic         busy,
  output logic         done,
  output logic         WE,
  output logic [4:0]   WAddr,
  output logic [63:0]  KeyIn
);

  localparam logic [4:0] LAST_IDX = 5'd25;
  localparam logic [4:0] RC_INIT  = 5'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h6;
      4'h1: y = 4'h5;
      4'h2: y = 4'hC;
      4'h3: y = 4'hA;
      4'h4: y = 4'h1;
      4'h5: y = 4'hE;
      4'h6: y = 4'h7;
      4'h7: y = 4'h9;
      4'h8: y = 4'hB;
      4'h9: y = 4'h0;
      4'hA: y = 4'h3;
      4'hB: y = 4'hD;
      4'hC: y = 4'h8;
      4'hD: y = 4'hF;
      4'hE: y = 4'h4;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // One key-register update: column S-box on the low 8 columns, a
  // generalised Feistel row mix, then round constant into Row0[4:0].
  function automatic logic [127:0] key_update(input logic [127:0] k,
                                              input logic [4:0]   rc);
    logic [31:0] r0, r1, r2, r3;
    logic [31:0] n0, n1, n2, n3;
    logic [3:0]  col;
    r0 = k[31:0];
    r1 = k[63:32];
    r2 = k[95:64];
    r3 = k[127:96];
    for (int j = 0; j < 8; j++) begin
      col   = sbox({r3[j], r2[j], r1[j], r0[j]});
      r0[j] = col[0];
      r1[j] = col[1];
      r2[j] = col[2];
      r3[j] = col[3];
    end
    n0 = {r0[23:0], r0[31:24]} ^ r1;
    n1 = r2;
    n2 = {r2[15:0], r2[31:16]} ^ r3;
    n3 = r0;
    n0[4:0] = n0[4:0] ^ rc;
    return {n3, n2, n1, n0};
  endfunction

  // Subkey is the low half-word of each row, Row3 in the top lane.
  function automatic logic [63:0] subkey_of(input logic [127:0] k);
    return {k[111:96], k[79:64], k[47:32], k[15:0]};
  endfunction

  function automatic logic [4:0] addr_map(input logic [4:0] idx);
`ifdef RECTANGLE128_KS_REVADDR_EN
    return LAST_IDX - idx;
`else
    return idx;
`endif
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [4:0]     rc_q, rc_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           we_q, we_d;
  logic [4:0]     waddr_q, waddr_d;
  logic [63:0]    keyin_q, keyin_d;
  logic [127:0]   key_next;

  assign key_next = key_update(key_q, rc_q);

  // Outputs are registered alongside the state, so the write presented in
  // a cycle always reflects the key register held in that same cycle.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    we_d    = 1'b0;
    waddr_d = 5'd0;
    keyin_d = 64'd0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_GEN;
          key_d   = Key;
          cnt_d   = 5'd0;
          rc_d    = RC_INIT;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          waddr_d = addr_map(5'd0);
          keyin_d = subkey_of(Key);
        end
      end
      ST_GEN: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
          cnt_d   = 5'd0;
          done_d  = 1'b1;
        end else begin
          key_d   = key_next;
          rc_d    = {rc_q[3:0], rc_q[4] ^ rc_q[2]};
          cnt_d   = cnt_q + 5'd1;
          we_d    = 1'b1;
          waddr_d = addr_map(cnt_q + 5'd1);
          keyin_d = subkey_of(key_next);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge flush) begin
    if (!flush) begin
      state_q <= ST_IDLE;
      key_q   <= 128'd0;
      cnt_q   <= 5'd0;
      rc_q    <= RC_INIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      keyin_q <= 64'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      keyin_q <= keyin_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign WE    = we_q;
  assign WAddr = waddr_q;
  assign KeyIn = keyin_q;

endmodule

// File: tb/tb_rectangle128_keysched.sv
// tb/tb_rectangle128_keysched.sv - randomized self-checking bench for rectangle128_keysched

module tb_rectangle128_keysched;

  logic         Clk;
  logic         flush;
  logic         start;
  logic [127:0] Key;
  logic         busy;
  logic         done;
  logic         WE;
  logic [4:0]   WAddr;
  logic [63:0]  KeyIn;

  int n_checks = 0;
  int n_fail   = 0;

  bit [63:0] exp_key [26];
  bit [63:0] got_key [26];
  bit [4:0]  got_addr[26];

  rectangle128_keysched dut (
    .Clk   (Clk),
    .flush (flush),
    .start (start),
    .Key   (Key),
    .busy  (busy),
    .done  (done),
    .WE    (WE),
    .WAddr (WAddr),
    .KeyIn (KeyIn)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] rotl32(input bit [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic int exp_addr(input int i);
`ifdef RECTANGLE128_KS_REVADDR_EN
    return 25 - i;
`else
    return i;
`endif
  endfunction

  // Reference schedule: rows as 32-bit words, S-box as a lookup table.
  function automatic void model(input logic [127:0] k);
    bit [31:0] row[4];
    bit [31:0] nr[4];
    int sb[16] = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};
    int rc = 1;
    int v, s;
    for (int r = 0; r < 4; r++) row[r] = k[32*r +: 32];
    for (int n = 0; n < 26; n++) begin
      exp_key[n] = (64'(row[3] & 32'hFFFF) << 48) | (64'(row[2] & 32'hFFFF) << 32) |
                   (64'(row[1] & 32'hFFFF) << 16) |  64'(row[0] & 32'hFFFF);
      for (int c = 0; c < 8; c++) begin
        v = 0;
        for (int r = 0; r < 4; r++) v += int'((row[r] >> c) & 1) << r;
        s = sb[v];
        for (int r = 0; r < 4; r++)
          row[r] = (row[r] & ~(32'd1 << c)) | (32'((s >> r) & 1) << c);
      end
      nr[0] = rotl32(row[0], 8) ^ row[1] ^ 32'(rc);
      nr[1] = row[2];
      nr[2] = rotl32(row[2], 16) ^ row[3];
      nr[3] = row[0];
      row = nr;
      rc = ((rc << 1) & 31) | (((rc >> 4) ^ (rc >> 2)) & 1);
    end
  endfunction

  // Request an expansion; returns at the negedge where write 0 is visible.
  task automatic kick(input logic [127:0] k);
    Key   = k;
    start = 1'b1;
    @(negedge Clk);
  endtask

  // Checks all 26 writes, scrambling Key and toggling start meanwhile.
  // Returns at the negedge of the done cycle.
  task automatic run_writes(input logic [127:0] k, input bit hold, input string tag);
    model(k);
    for (int i = 0; i < 26; i++) begin
      got_key[i]  = KeyIn;
      got_addr[i] = WAddr;
      check($sformatf("%s_w%0d_we", tag, i), 128'(WE), 128'(1));
      check($sformatf("%s_w%0d_busy", tag, i), 128'(busy), 128'(1));
      check($sformatf("%s_w%0d_addr", tag, i), 128'(WAddr), 128'(exp_addr(i)));
      check($sformatf("%s_w%0d_data", tag, i), 128'(KeyIn), 128'(exp_key[i]));
      Key   = {$urandom(), $urandom(), $urandom(), $urandom()};
      start = hold ? 1'b1 : ((i < 25) ? 1'($urandom_range(0, 1)) : 1'b0);
      @(negedge Clk);
    end
    check({tag, "_done_pulse"}, 128'(done), 128'(1));
    check({tag, "_done_busy"}, 128'(busy), 128'(1));
    check({tag, "_done_we"}, 128'(WE), 128'(0));
    check({tag, "_done_addr"}, 128'(WAddr), 128'(0));
    check({tag, "_done_data"}, 128'(KeyIn), 128'(0));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_done"}, 128'(done), 128'(0));
    check({tag, "_idle_busy"}, 128'(busy), 128'(0));
    check({tag, "_idle_we"}, 128'(WE), 128'(0));
    check({tag, "_idle_addr"}, 128'(WAddr), 128'(0));
    check({tag, "_idle_data"}, 128'(KeyIn), 128'(0));
  endtask

  initial begin
    logic [127:0] k, k2;
    flush = 1'b0;
    start = 1'b0;
    Key   = 128'd0;
    repeat (2) @(negedge Clk);
    check_idle("reset");
    flush = 1'b1;
    @(negedge Clk);
    check_idle("post_reset");

    // All-zero key with known first two subkeys.
    kick(128'd0);
    run_writes(128'd0, 1'b0, "zero");
    check("zero_vec_w0", 128'(got_key[0]), 128'(64'h0));
    check("zero_vec_w1", 128'(got_key[1]), 128'(64'h0000_0000_00FF_00FE));
`ifdef RECTANGLE128_KS_REVADDR_EN
    check("zero_vec_a0", 128'(got_addr[0]), 128'(25));
    check("zero_vec_a1", 128'(got_addr[1]), 128'(24));
    check("zero_vec_a25", 128'(got_addr[25]), 128'(0));
`else
    check("zero_vec_a0", 128'(got_addr[0]), 128'(0));
    check("zero_vec_a25", 128'(got_addr[25]), 128'(25));
`endif
    @(negedge Clk);
    check_idle("zero");

    // Known-answer first subkey.
    k = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    kick(k);
    run_writes(k, 1'b0, "kat");
    check("kat_vec_w0", 128'(got_key[0]), 128'(64'h4567_CDEF_BA98_3210));
    @(negedge Clk);
    check_idle("kat");

    // Random keys, with idle gaps of random length.
    for (int t = 0; t < 3; t++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      kick(k);
      run_writes(k, 1'b0, $sformatf("rnd%0d", t));
      repeat ($urandom_range(1, 3)) @(negedge Clk);
      check_idle($sformatf("rnd%0d", t));
    end

    // Abort during write 10, then a clean rerun of the same key.
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    model(k);
    kick(k);
    start = 1'b0;
    repeat (10) @(negedge Clk);
    check("abort_w10_we", 128'(WE), 128'(1));
    check("abort_w10_data", 128'(KeyIn), 128'(exp_key[10]));
    flush = 1'b0;
    #1;
    check_idle("abort_now");
    repeat (3) @(negedge Clk);
    check_idle("abort_hold");
    flush = 1'b1;
    @(negedge Clk);
    check_idle("abort_release");
    kick(k);
    run_writes(k, 1'b0, "rerun");
    @(negedge Clk);
    check_idle("rerun");

    // start held high: back-to-back expansions with one IDLE cycle between.
    k  = {$urandom(), $urandom(), $urandom(), $urandom()};
    k2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    kick(k);
    run_writes(k, 1'b1, "b2b_a");
    Key = k2;
    @(negedge Clk);
    check_idle("b2b_gap");
    @(negedge Clk);
    run_writes(k2, 1'b0, "b2b_b");
    @(negedge Clk);
    check_idle("b2b_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rectangle128_keysched.md
RECTANGLE128_KEYSCHED -- requirements
Module: rectangle128_keysched

Interface
REQ-001 The block SHALL expose: Clk  input  1  single system clock, all state rising-edge.
REQ-002 The block SHALL expose: flush  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL expose: start  input  1  request to expand Key, sampled only in IDLE.
REQ-004 The block SHALL expose: Key  input  128  master key; Row0=Key[31:0], Row1=Key[63:32], Row2=Key[95:64], Row3=Key[127:96].
REQ-005 The block SHALL expose: busy  output  1  high in GEN and DONE.
REQ-006 The block SHALL expose: done  output  1  one-cycle pulse after last subkey write.
REQ-007 The block SHALL expose: WE  output  1  subkey write strobe to subkey memory.
REQ-008 The block SHALL expose: WAddr  output  5  subkey index 0..25.
REQ-009 The block SHALL expose: KeyIn  output  64  subkey data, valid when WE=1.

Function
REQ-010 FSM SHALL have states IDLE, GEN, DONE; IDLE->GEN on start=1; GEN->DONE when cnt==25 write issues; DONE->IDLE unconditionally.
REQ-011 On IDLE with start=1 the block SHALL load Key into the 128-bit key register, cnt<=0, rc<=5'h01.
REQ-012 start SHALL be ignored in GEN and DONE; Key SHALL be sampled only on the accepting edge.
REQ-013 In GEN, each cycle SHALL assert WE=1, WAddr=cnt, KeyIn={Row3[15:0],Row2[15:0],Row1[15:0],Row0[15:0]} of current register, then update register, rc and cnt.
REQ-014 Update step 1: 4-bit S-box {6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2} SHALL be applied to columns 0..7, column j input = {Row3[j],Row2[j],Row1[j],Row0[j]}.
REQ-015 Update step 2: Row0'=(Row0<<<8)^Row1, Row1'=Row2, Row2'=(Row2<<<16)^Row3, Row3'=Row0 (rotates left, 32-bit).
REQ-016 Update step 3: Row0'[4:0] SHALL be XORed with rc; rc SHALL advance rc<={rc[3:0],rc[4]^rc[2]}.
REQ-017 Latency: start accepted at edge N -> WE high for exactly 26 cycles following edge N, WAddr 0..25 consecutive, done high the cycle after.
REQ-018 Outside GEN, WE SHALL be 0 and WAddr/KeyIn SHALL be 0.
REQ-019 cnt SHALL be 5 bits and never exceed 25; no wrap to 26..31 SHALL occur.
REQ-020 start held high continuously SHALL produce back-to-back expansions separated by DONE, with a new Key sampled in each IDLE.

Reset
REQ-021 flush=0 SHALL asynchronously force IDLE, cnt=0, rc=5'h01, key register=0, busy=0, done=0, WE=0, WAddr=0, KeyIn=0.
REQ-022 flush asserted mid-GEN SHALL abort immediately; no further WE pulses; the next start SHALL restart from index 0.

Configuration
REQ-023 Macro RECTANGLE128_KS_REVADDR_EN defined: WAddr SHALL be 25-cnt (subkey i written to address 25-i, decryption order); data sequence unchanged.
REQ-024 Macro RECTANGLE128_KS_REVADDR_EN undefined: WAddr SHALL equal cnt (REQ-013).

Verification
REQ-025 Key=0, start pulse -> write 0: KeyIn=64'h0; write 1: KeyIn=64'h0000_0000_00FF_00FE; 26 writes total, done one cycle after.
REQ-026 Key=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> first write KeyIn=64'h4567_CDEF_BA98_3210, WAddr=0; full sequence matches golden C model.
REQ-027 flush low during write 10 -> WE=0, busy=0 immediately; then start -> writes restart at WAddr=0 with identical data to a clean run.
REQ-028 start pulses during GEN -> no effect, exactly 26 writes; start held high -> second expansion begins the cycle after DONE.
REQ-029 RECTANGLE128_KS_REVADDR_EN defined, Key=0 -> first write WAddr=25 KeyIn=0, second WAddr=24 KeyIn=64'h0000_0000_00FF_00FE, last WAddr=0.
